// File: rtl/ecc_apb_regfile_pkg.sv
// Shared constants and types for the ECC APB register bank.
package ecc_apb_pkg;

  // Register byte offsets. Full-address compare, so misaligned and
  // out-of-map addresses never match.
  localparam logic [31:0] OFF_CTRL     = 32'h0000_0000;
  localparam logic [31:0] OFF_DATA_IN  = 32'h0000_0004;
  localparam logic [31:0] OFF_CW_WIDTH = 32'h0000_0008;
  localparam logic [31:0] OFF_NOISE    = 32'h0000_000C;
  localparam logic [31:0] OFF_DATA_OUT = 32'h0000_0010;
  localparam logic [31:0] OFF_NERR     = 32'h0000_0014;

  typedef enum logic [1:0] {
    MODE_ENC  = 2'b00,
    MODE_DEC  = 2'b01,
    MODE_FULL = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    CW_8    = 2'b00,
    CW_16   = 2'b01,
    CW_32   = 2'b10,
    CW_RSVD = 2'b11
  } cw_e;

  typedef enum logic [1:0] {
    NERR_NONE   = 2'b00,
    NERR_SINGLE = 2'b01,
    NERR_DOUBLE = 2'b10,
    NERR_RSVD   = 2'b11
  } nerr_e;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'b00,
    APB_SETUP  = 2'b01,
    APB_ACCESS = 2'b10
  } apb_state_e;

  typedef enum logic [2:0] {
    SEL_CTRL, SEL_DIN, SEL_CW, SEL_NOISE, SEL_DOUT, SEL_NERR, SEL_NONE
  } reg_sel_e;

  // Result captured from the core on core_done.
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  nerr;
  } core_res_t;

  // Map a zero-extended byte address to a register select.
  function automatic reg_sel_e decode_addr(input logic [31:0] a);
    case (a)
      OFF_CTRL:     return SEL_CTRL;
      OFF_DATA_IN:  return SEL_DIN;
      OFF_CW_WIDTH: return SEL_CW;
      OFF_NOISE:    return SEL_NOISE;
      OFF_DATA_OUT: return SEL_DOUT;
      OFF_NERR:     return SEL_NERR;
      default:      return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ecc_apb_regfile_phase_tracker.sv
// APB phase tracker. state_q holds the bus phase of the previous cycle;
// the strobes classify the current cycle so the regfile can act on the
// edge that ends it (write commit at end of ACCESS, read load at end of SETUP).
module apb_phase_tracker
  import ecc_apb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic psel,
  input  logic penable,
  output logic setup_phase,
  output logic access_phase
);

  apb_state_e state_q;

  // Current-cycle phase strobes: ACCESS only counts when it follows SETUP.
  always_comb begin
    setup_phase  = psel & ~penable;
    access_phase = (state_q == APB_SETUP) & psel & penable;
  end

  // Phase FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= APB_IDLE;
    end else begin
      case (state_q)
        APB_IDLE:   state_q <= (psel & ~penable) ? APB_SETUP : APB_IDLE;
        APB_SETUP:  state_q <= APB_ACCESS;
        APB_ACCESS: state_q <= (psel & ~penable) ? APB_SETUP : APB_IDLE;
        default:    state_q <= APB_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ecc_apb_regfile.sv
// ECC APB register bank: config registers, start pulse, result capture.
module ecc_apb_regfile
  import ecc_apb_pkg::*;
#(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       PREADY,
  output logic [1:0]                 ctrl_mode,
  output logic [AMBA_WORD-1:0]       data_in,
  output logic [1:0]                 cw_width,
  output logic [AMBA_WORD-1:0]       noise,
  output logic                       start,
  input  logic                       core_busy,
  input  logic                       core_done,
  input  logic [AMBA_WORD-1:0]       core_data,
  input  logic [1:0]                 core_nerr
);

  logic                 setup_phase;
  logic                 access_phase;
  logic [31:0]          paddr_ext;
  reg_sel_e             sel;
  logic                 wr_ok;
  logic [AMBA_WORD-1:0] rd_mux;

  logic [1:0]           ctrl_q;
  logic [AMBA_WORD-1:0] din_q;
  logic [1:0]           cw_q;
  logic [AMBA_WORD-1:0] noise_q;
  logic [AMBA_WORD-1:0] dout_q;
  logic [1:0]           nerr_q;

  apb_phase_tracker u_phase (
    .clk          (clk),
    .rst_n        (rst_n),
    .psel         (PSEL),
    .penable      (PENABLE),
    .setup_phase  (setup_phase),
    .access_phase (access_phase)
  );

  assign PREADY    = 1'b1;
  assign paddr_ext = 32'(PADDR);
  assign sel       = decode_addr(paddr_ext);
  // Config writes are frozen while the core is running.
  assign wr_ok     = access_phase & PWRITE & ~core_busy;

  assign ctrl_mode = ctrl_q;
  assign data_in   = din_q;
  assign cw_width  = cw_q;
  assign noise     = noise_q;

  // Read mux; narrow registers zero-extended, unmapped reads as 0.
  always_comb begin
    rd_mux = '0;
    case (sel)
      SEL_CTRL:  rd_mux = AMBA_WORD'(ctrl_q);
      SEL_DIN:   rd_mux = din_q;
      SEL_CW:    rd_mux = AMBA_WORD'(cw_q);
      SEL_NOISE: rd_mux = noise_q;
      SEL_DOUT:  rd_mux = dout_q;
      SEL_NERR:  rd_mux = AMBA_WORD'(nerr_q);
      default:   rd_mux = '0;
    endcase
  end

  // Config registers and start pulse; start follows a committed CTRL write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      din_q   <= '0;
      cw_q    <= '0;
      noise_q <= '0;
      start   <= 1'b0;
    end else begin
      start <= 1'b0;
      if (wr_ok) begin
        case (sel)
          SEL_CTRL: begin
            ctrl_q <= PWDATA[1:0];
            start  <= (mode_e'(PWDATA[1:0]) != MODE_RSVD);
          end
          SEL_DIN:   din_q <= PWDATA;
          SEL_CW:    if (cw_e'(PWDATA[1:0]) != CW_RSVD) cw_q <= PWDATA[1:0];
          SEL_NOISE: noise_q <= PWDATA;
          default:   ;
        endcase
      end
    end
  end

  // Result capture from the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      nerr_q <= '0;
    end else if (core_done) begin
      dout_q <= core_data;
      nerr_q <= core_nerr;
    end
  end

  // Read data loads at the end of SETUP and holds until the next read SETUP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) PRDATA <= '0;
    else if (setup_phase && !PWRITE) PRDATA <= rd_mux;
  end

endmodule

// File: tb/tb_ecc_apb_regfile.sv
// Randomized self-checking bench for ecc_apb_regfile with a register-map model.
module tb_ecc_apb_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] PADDR = '0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic [1:0]  ctrl_mode, cw_width;
  logic [31:0] data_in, noise;
  logic        start;
  logic        core_busy = 1'b0, core_done = 1'b0;
  logic [31:0] core_data = '0;
  logic [1:0]  core_nerr = '0;

  int checks = 0;
  int errors = 0;
  bit exp_start = 1'b0;
  int start_seen = 0;

  // Model: the six registers indexed by offset/4.
  logic [31:0] m_reg [6];
  logic [19:0] addr_tab [9];

  ecc_apb_regfile #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20)) dut (
    .clk(clk), .rst_n(rst_n), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .ctrl_mode(ctrl_mode), .data_in(data_in), .cw_width(cw_width), .noise(noise),
    .start(start), .core_busy(core_busy), .core_done(core_done),
    .core_data(core_data), .core_nerr(core_nerr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Every cycle: start must match the one-cycle expectation set by the last write.
  always @(negedge clk) begin
    chk("start", {31'b0, start}, {31'b0, exp_start});
    if (start) start_seen++;
    exp_start = 1'b0;
  end

  function automatic int m_idx(input logic [19:0] a);
    case (a)
      20'h00: return 0;
      20'h04: return 1;
      20'h08: return 2;
      20'h0C: return 3;
      20'h10: return 4;
      20'h14: return 5;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [19:0] a);
    int i = m_idx(a);
    return (i < 0) ? 32'h0 : m_reg[i];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 6; i++) m_reg[i] = '0;
  endtask

  // Returns whether this write should produce a start pulse.
  task automatic m_write(input logic [19:0] a, input logic [31:0] d, input bit busy,
                         output bit pulse);
    int i = m_idx(a);
    pulse = 1'b0;
    if (busy || i < 0 || i > 3) return;
    case (i)
      0: begin m_reg[0] = {30'b0, d[1:0]}; pulse = (d[1:0] != 2'b11); end
      1: m_reg[1] = d;
      2: if (d[1:0] != 2'b11) m_reg[2] = {30'b0, d[1:0]};
      default: m_reg[3] = d;
    endcase
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".ctrl_mode"}, {30'b0, ctrl_mode}, m_reg[0]);
    chk({tag, ".data_in"},   data_in,             m_reg[1]);
    chk({tag, ".cw_width"},  {30'b0, cw_width},  m_reg[2]);
    chk({tag, ".noise"},     noise,               m_reg[3]);
  endtask

  // Tasks enter and leave just after a rising edge, so chaining them gives
  // back-to-back transfers with no idle cycle.
  task automatic apb_write(input logic [19:0] a, input logic [31:0] d, input bit busy);
    bit p;
    core_busy = busy; PADDR = a; PWRITE = 1'b1; PWDATA = d; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1 PENABLE = 1'b1;
    chk("wr.pready", {31'b0, PREADY}, 32'h1);
    @(posedge clk); #1 PSEL = 1'b0; PENABLE = 1'b0; core_busy = 1'b0;
    m_write(a, d, busy, p);
    exp_start = p;
    chk_outs("wr");
  endtask

  task automatic apb_read(input logic [19:0] a);
    logic [31:0] exp;
    exp = m_read(a);
    PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1 PENABLE = 1'b1;
    chk("rd.prdata", PRDATA, exp);
    chk("rd.pready", {31'b0, PREADY}, 32'h1);
    @(posedge clk); #1 PSEL = 1'b0; PENABLE = 1'b0;
    chk("rd.hold", PRDATA, exp);
  endtask

  task automatic core_pulse(input logic [31:0] d, input logic [1:0] n);
    core_done = 1'b1; core_data = d; core_nerr = n;
    @(posedge clk); #1 core_done = 1'b0;
    m_reg[4] = d; m_reg[5] = {30'b0, n};
  endtask

  task automatic read_all();
    for (int i = 0; i < 6; i++) apb_read(20'(i * 4));
  endtask

  initial begin
    logic [19:0] a;
    logic [31:0] d;
    int op;
    addr_tab = '{20'h00, 20'h04, 20'h08, 20'h0C, 20'h10, 20'h14, 20'h1C, 20'h02, 20'h80010};
    m_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst.prdata", PRDATA, 32'h0);
    chk("rst.pready", {31'b0, PREADY}, 32'h1);
    chk_outs("rst");
    read_all();
    chk("rst.no_start", start_seen, 0);

    // Configure and launch.
    apb_write(20'h04, 32'hA5A5_5A5A, 1'b0);
    apb_write(20'h08, 32'h2, 1'b0);
    apb_write(20'h00, 32'h1, 1'b0);
    @(posedge clk); #1;
    chk("launch.start_count", start_seen, 1);

    // Busy core drops config writes.
    apb_write(20'h04, 32'h1234, 1'b1);
    apb_write(20'h00, 32'h0, 1'b1);
    @(posedge clk); #1;
    chk("busy.start_count", start_seen, 1);

    // Result capture.
    core_pulse(32'hDEAD_BEEF, 2'd1);
    apb_read(20'h10);
    apb_read(20'h14);

    // Dropped / ignored writes.
    apb_write(20'h08, 32'h3, 1'b0);
    apb_write(20'h10, 32'h99, 1'b0);
    apb_write(20'h1C, 32'hFFFF_FFFF, 1'b0);
    apb_read(20'h1C);
    apb_read(20'h10);
    apb_write(20'h00, 32'h3, 1'b0);
    apb_read(20'h00);

    // core_done concurrent with a DATA_OUT read SETUP returns the old value.
    d = m_reg[4];
    PADDR = 20'h10; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    core_done = 1'b1; core_data = 32'h0BAD_F00D; core_nerr = 2'd2;
    @(posedge clk); #1 PENABLE = 1'b1; core_done = 1'b0;
    m_reg[4] = 32'h0BAD_F00D; m_reg[5] = 32'h2;
    chk("race.old", PRDATA, d);
    @(posedge clk); #1 PSEL = 1'b0; PENABLE = 1'b0;
    apb_read(20'h10);
    apb_read(20'h14);

    // Randomized traffic.
    for (int it = 0; it < 400; it++) begin
      op = $urandom_range(0, 9);
      a  = addr_tab[$urandom_range(0, 8)];
      d  = $urandom;
      if (op <= 3) apb_write(a, d, ($urandom_range(0, 3) == 0));
      else if (op <= 7) apb_read(a);
      else if (op == 8) core_pulse($urandom, 2'($urandom_range(0, 2)));
      else begin @(posedge clk); #1; end
    end
    read_all();

    // Reset during ACCESS of a CTRL write: write lost, no start.
    apb_write(20'h0C, 32'hCAFE_0001, 1'b0);
    PADDR = 20'h00; PWRITE = 1'b1; PWDATA = 32'h2; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1 PENABLE = 1'b1; rst_n = 1'b0;
    m_reset();
    #1 chk_outs("midrst");
    @(posedge clk); #1 PSEL = 1'b0; PENABLE = 1'b0; rst_n = 1'b1;
    chk("midrst.prdata", PRDATA, 32'h0);
    repeat (2) begin @(posedge clk); #1; end
    chk_outs("postrst");
    read_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecc_apb_regfile.md
# ecc_apb_regfile

Register bank directly downstream of the APB slave phase FSM in the ECC encoder/decoder. It commits APB writes into the configuration registers and returns read data for APB reads. It sends the configuration and a one-cycle start pulse to the ECC core. When the core finishes, it captures the core's results into read-only status registers.

## Interface
- AMBA_WORD, 32, APB data width; also the DATA_IN and DATA_OUT width
- AMBA_ADDR_WIDTH, 20, APB address width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- PADDR  in  AMBA_ADDR_WIDTH  byte address
- PSEL, PENABLE, PWRITE  in  1 each  APB control
- PWDATA  in  AMBA_WORD  write data
- PRDATA  out  AMBA_WORD  read data, registered
- PREADY  out  1  tied high; no wait states
- ctrl_mode  out  2  00 encode, 01 decode, 10 full channel, 11 reserved
- data_in  out  AMBA_WORD  operand for the core
- cw_width  out  2  00 = 8 bit, 01 = 16 bit, 10 = 32 bit
- noise  out  AMBA_WORD  error-injection mask
- start  out  1  one-cycle operation request
- core_busy  in  1  core operation in progress
- core_done  in  1  one-cycle result-valid pulse
- core_data  in  AMBA_WORD  result word
- core_nerr  in  2  00 = no error, 01 = single error, 10 = double error

## Operation
- Register map, byte offsets. Full PADDR is decoded. Any other address, or any address with PADDR[1:0]≠0, is unmapped: reads return 0 and writes are ignored.
  - 0x00 CTRL, R/W, bits[1:0]
  - 0x04 DATA_IN, R/W
  - 0x08 CW_WIDTH, R/W, bits[1:0]
  - 0x0C NOISE, R/W
  - 0x10 DATA_OUT, RO
  - 0x14 NUM_OF_ERRORS, RO, bits[1:0]
- Unused bits of narrow registers read as 0. Writes to RO registers are ignored.
- Phase tracker FSM states: IDLE, SETUP, ACCESS.
  - IDLE→SETUP on PSEL & !PENABLE.
  - SETUP→ACCESS unconditionally.
  - ACCESS→SETUP on PSEL & !PENABLE, else →IDLE.
- Write commit: in ACCESS with PSEL & PENABLE & PWRITE.
- While core_busy=1, writes to CTRL, DATA_IN, CW_WIDTH and NOISE are dropped and produce no start pulse.
- A CW_WIDTH write of 2'b11 is dropped; the old value is kept.
- A CTRL write of mode 11 updates the register but does not generate start.
- Start: a committed CTRL write with mode≠11 asserts start in the following cycle, for exactly one cycle.
- Results: core_done=1 loads core_data into DATA_OUT and core_nerr into NUM_OF_ERRORS on the same edge.
- Reset values: every register, PRDATA, start, ctrl_mode, data_in, cw_width and noise are 0. PREADY is 1. The FSM is in IDLE.

## Timing
- Write: SETUP in cycle T0, ACCESS in T1.
  - The register updates on the T1→T2 edge.
  - Outputs show the new value in T2.
  - start is high in T2 only.
- Read: PRDATA is loaded on the T0→T1 edge, from the SETUP-cycle decode. It is valid throughout ACCESS and held until the next read SETUP.
- core_done in the same cycle as a read SETUP of DATA_OUT: PRDATA returns the old value; the next read returns the new one.
- Back-to-back transfers (ACCESS followed directly by SETUP): supported with no idle cycle.
- Reset asserted mid-transfer: immediate return to reset state. A write in flight is lost; a start not yet asserted is never asserted.
- Unmapped or ignored accesses still complete in 2 cycles with PREADY=1.

## Structure
- Package ecc_apb_pkg:
  - register offset constants
  - mode and codeword-width encodings
  - nerr encodings
  - APB phase state enum
- Sub-module apb_phase_tracker: the IDLE/SETUP/ACCESS FSM. Outputs setup_phase and access_phase strobes.
- The top level holds address decode, registers, the start pulse and the result capture.

## Test plan
- Reset, then read all six offsets → PRDATA = 0 each time; start never asserted.
- Write DATA_IN=0xA5A5_5A5A, CW_WIDTH=2, then CTRL=1 → data_in=0xA5A5_5A5A and cw_width=2; start high for exactly 1 cycle, in the cycle after the CTRL ACCESS cycle.
- Hold core_busy=1, write DATA_IN=0x1234 and CTRL=0 → data_in keeps its prior value; no start.
- Pulse core_done with core_data=0xDEAD_BEEF and core_nerr=1 → read 0x10 gives 0xDEAD_BEEF; read 0x14 gives 0x1.
- Write 0x3 to CW_WIDTH, 0x99 to 0x10, and any value to 0x1C → cw_width, DATA_OUT and the 0x1C read (=0) are all unchanged.
- Assert rst_n=0 during the ACCESS cycle of a CTRL write → no start; all outputs read 0 after reset.
